// File: rtl/klotski_pkg.sv
// Shared types and cell-index helpers for the Klotski move executor and solver.
package klotski_pkg;

  // Cell index packing shared with the solver: {row[1:0], col[1:0]}.
  localparam int CELL_W = 4;
  localparam int AXIS_W = 2;

  typedef logic [CELL_W-1:0] cell_t;
  typedef logic [AXIS_W-1:0] axis_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TO_START,
    S_GRAB,
    S_TO_END,
    S_RELEASE,
    S_DONE
  } exec_state_t;

  // Sub-phase of a travel state: column axis first, then row axis.
  typedef enum logic [1:0] {
    LEG_X_LAUNCH,
    LEG_X_WAIT,
    LEG_Y_LAUNCH,
    LEG_Y_WAIT
  } travel_leg_t;

  function automatic axis_t cell_row(input cell_t idx);
    return idx[3:2];
  endfunction

  function automatic axis_t cell_col(input cell_t idx);
    return idx[1:0];
  endfunction

  // Unsigned distance between two coordinates on one axis.
  function automatic axis_t axis_delta(input axis_t from, input axis_t to);
    return (to >= from) ? axis_t'(to - from) : axis_t'(from - to);
  endfunction

endpackage

// File: rtl/klotski_move_executor_stepper_pulser.sv
// Generates a burst of step pulses (STEP_HALF cycles high, STEP_HALF low each)
// and a one-cycle done once the last low phase has elapsed.
module stepper_pulser #(
  parameter int STEP_HALF = 25000,
  parameter int CNT_W     = 10,
  parameter int TMR_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             dir,
  output logic             step,
  output logic             dir_out,
  output logic             done
);

  logic             active;
  logic [CNT_W-1:0] remaining;
  logic [TMR_W-1:0] timer;

  // Phase sequencer: high half, low half, repeat until remaining steps are used.
  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      step      <= 1'b0;
      done      <= 1'b0;
      dir_out   <= 1'b0;
      timer     <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          dir_out <= dir;
          if (count == '0) begin
            done <= 1'b1;
          end else begin
            active    <= 1'b1;
            step      <= 1'b1;
            timer     <= TMR_W'(STEP_HALF - 1);
            remaining <= count;
          end
        end
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end else if (step) begin
        step  <= 1'b0;
        timer <= TMR_W'(STEP_HALF - 1);
      end else if (remaining == CNT_W'(1)) begin
        active <= 1'b0;
        done   <= 1'b1;
      end else begin
        remaining <= remaining - 1'b1;
        step      <= 1'b1;
        timer     <= TMR_W'(STEP_HALF - 1);
      end
    end
  end

endmodule

// File: rtl/klotski_move_executor.sv
// Executes one tile move: travel to start cell, grab, travel to end cell,
// release, then pulse o_continue back to the solver.
module klotski_move_executor #(
  parameter int STEPS_PER_CELL = 200,
  parameter int STEP_HALF      = 25000,
  parameter int SETTLE         = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [3:0] i_start_block,
  input  logic [3:0] i_end_block,
  output logic       o_continue,
  output logic       o_busy,
  output logic       o_magnet,
  output logic       o_x_step,
  output logic       o_x_dir,
  output logic       o_y_step,
  output logic       o_y_dir,
  output logic [3:0] o_pos
);

  import klotski_pkg::*;

  localparam int CNT_W   = $clog2(3 * STEPS_PER_CELL + 1);
  localparam int TMR_MAX = (STEP_HALF > SETTLE) ? STEP_HALF : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  exec_state_t      state, state_n;
  travel_leg_t      leg, leg_n;
  cell_t            start_q, start_n, end_q, end_n, pos, pos_n;
  logic [TMR_W-1:0] settle, settle_n;
  logic             axis_y, axis_y_n;
  logic             travel_done;

  logic             pls_start;
  logic [CNT_W-1:0] pls_count;
  logic             pls_dir;
  logic             pls_step, pls_dir_out, pls_done;

  cell_t            tgt;
  axis_t            col_d, row_d;
  logic             col_up, row_up;

  function automatic logic [CNT_W-1:0] steps_for(input axis_t delta);
    return CNT_W'(delta) * CNT_W'(STEPS_PER_CELL);
  endfunction

  assign tgt    = (state == S_TO_END) ? end_q : start_q;
  assign col_d  = axis_delta(cell_col(pos), cell_col(tgt));
  assign row_d  = axis_delta(cell_row(pos), cell_row(tgt));
  assign col_up = cell_col(tgt) > cell_col(pos);
  assign row_up = cell_row(tgt) > cell_row(pos);

  stepper_pulser #(
    .STEP_HALF (STEP_HALF),
    .CNT_W     (CNT_W),
    .TMR_W     (TMR_W)
  ) u_pulser (
    .clk     (i_clk),
    .rst     (i_rst),
    .start   (pls_start),
    .count   (pls_count),
    .dir     (pls_dir),
    .step    (pls_step),
    .dir_out (pls_dir_out),
    .done    (pls_done)
  );

  // Control state register; reset aborts any move and forgets the position.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      leg    <= LEG_X_LAUNCH;
      pos    <= '0;
      settle <= '0;
      axis_y <= 1'b0;
    end else begin
      state  <= state_n;
      leg    <= leg_n;
      pos    <= pos_n;
      settle <= settle_n;
      axis_y <= axis_y_n;
    end
  end

  // Move request latch; only meaningful while busy, so no reset needed.
  always_ff @(posedge i_clk) begin
    start_q <= start_n;
    end_q   <= end_n;
  end

  // Next-state logic: travel legs, settle timing and move sequencing.
  always_comb begin
    state_n     = state;
    leg_n       = leg;
    start_n     = start_q;
    end_n       = end_q;
    pos_n       = pos;
    settle_n    = settle;
    axis_y_n    = axis_y;
    travel_done = 1'b0;
    pls_start   = 1'b0;
    pls_count   = '0;
    pls_dir     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_en) begin
          start_n = i_start_block;
          end_n   = i_end_block;
          leg_n   = LEG_X_LAUNCH;
          state_n = S_TO_START;
        end
      end
      S_TO_START, S_TO_END: begin
        case (leg)
          LEG_X_LAUNCH: begin
            if (col_d == '0) begin
              leg_n = LEG_Y_LAUNCH;
            end else begin
              pls_start = 1'b1;
              pls_count = steps_for(col_d);
              pls_dir   = col_up;
              axis_y_n  = 1'b0;
              leg_n     = LEG_X_WAIT;
            end
          end
          LEG_X_WAIT: begin
            if (pls_done) leg_n = LEG_Y_LAUNCH;
          end
          LEG_Y_LAUNCH: begin
            if (row_d == '0) begin
              travel_done = 1'b1;
            end else begin
              pls_start = 1'b1;
              pls_count = steps_for(row_d);
              pls_dir   = row_up;
              axis_y_n  = 1'b1;
              leg_n     = LEG_Y_WAIT;
            end
          end
          LEG_Y_WAIT: begin
            if (pls_done) travel_done = 1'b1;
          end
          default: leg_n = LEG_X_LAUNCH;
        endcase
        if (travel_done) begin
          pos_n    = tgt;
          leg_n    = LEG_X_LAUNCH;
          settle_n = TMR_W'(SETTLE - 1);
          if (state == S_TO_END)     state_n = S_RELEASE;
          else if (start_q == end_q) state_n = S_DONE;
          else                       state_n = S_GRAB;
        end
      end
      S_GRAB: begin
        if (settle == '0) state_n  = S_TO_END;
        else              settle_n = settle - 1'b1;
      end
      S_RELEASE: begin
        if (settle == '0) state_n  = S_DONE;
        else              settle_n = settle - 1'b1;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign o_busy     = (state != S_IDLE);
  assign o_continue = (state == S_DONE);
  assign o_magnet   = (state == S_GRAB) || (state == S_TO_END);
  assign o_x_step   = pls_step & ~axis_y;
  assign o_y_step   = pls_step & axis_y;
  assign o_x_dir    = pls_dir_out & ~axis_y;
  assign o_y_dir    = pls_dir_out & axis_y;
  assign o_pos      = pos;

endmodule
